// File: rtl/fetch_queue.sv
// fetch_queue: in-order {pc, instr} buffer between the IFU and decode, with flush on redirect.
// Ports: clk, reset (async, active-low); push_valid/push_pc/push_instr/push_ready from the IFU;
// flush discards every entry; pop_ready/pop_valid/pop_pc/pop_instr/pop_pc_plus_4 toward decode;
// count is the occupancy. Defining FETCH_QUEUE_STATS_EN adds the saturating counters
// stat_full_cycles, stat_flushes and stat_dropped.
module fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_valid,
  input  logic [31:0]              push_pc,
  input  logic [31:0]              push_instr,
  output logic                     push_ready,
  input  logic                     flush,
  input  logic                     pop_ready,
  output logic                     pop_valid,
  output logic [31:0]              pop_pc,
  output logic [31:0]              pop_instr,
  output logic [31:0]              pop_pc_plus_4,
  output logic [$clog2(DEPTH):0]   count
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]              stat_full_cycles,
  output logic [31:0]              stat_flushes,
  output logic [31:0]              stat_dropped
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]   rd_ptr, wr_ptr;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic          push_fire, pop_fire;
  // push_ready and pop_valid depend only on registered pointers, so decode never reaches the IFU combinationally
  always_comb begin
    count         = wr_ptr - rd_ptr;
    push_ready    = count != (AW+1)'(DEPTH);
    pop_valid     = count != '0;
    push_fire     = push_valid & push_ready & ~flush;
    pop_fire      = pop_valid & pop_ready & ~flush;
    pop_pc        = pop_valid ? pc_mem[rd_ptr[AW-1:0]] : 32'd0;
    pop_instr     = pop_valid ? instr_mem[rd_ptr[AW-1:0]] : NOP_INSTR;
    pop_pc_plus_4 = pop_pc + 32'd4;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= rd_ptr;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_fire)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (push_fire) begin
      pc_mem[wr_ptr[AW-1:0]]    <= push_pc;
      instr_mem[wr_ptr[AW-1:0]] <= push_instr;
    end
`ifdef FETCH_QUEUE_STATS_EN
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      stat_full_cycles <= '0;
      stat_flushes     <= '0;
      stat_dropped     <= '0;
    end else begin
      if (!push_ready) stat_full_cycles <= sat_add(stat_full_cycles, 32'd1);
      if (flush) begin
        stat_flushes <= sat_add(stat_flushes, 32'd1);
        stat_dropped <= sat_add(stat_dropped, 32'(count) + 32'(push_valid));
      end
    end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue at DEPTH=4.
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        push_valid = 1'b0;
  logic [31:0] push_pc = '0;
  logic [31:0] push_instr = '0;
  logic        push_ready;
  logic        flush = 1'b0;
  logic        pop_ready = 1'b0;
  logic        pop_valid;
  logic [31:0] pop_pc, pop_instr, pop_pc_plus_4;
  logic [2:0]  count;
`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stat_full_cycles, stat_flushes, stat_dropped;
`endif
  int          errors = 0;
  int          checks = 0;
  fetch_queue #(.DEPTH(4), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .reset(reset),
    .push_valid(push_valid), .push_pc(push_pc), .push_instr(push_instr), .push_ready(push_ready),
    .flush(flush), .pop_ready(pop_ready), .pop_valid(pop_valid), .pop_pc(pop_pc),
    .pop_instr(pop_instr), .pop_pc_plus_4(pop_pc_plus_4), .count(count)
`ifdef FETCH_QUEUE_STATS_EN
    , .stat_full_cycles(stat_full_cycles), .stat_flushes(stat_flushes), .stat_dropped(stat_dropped)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [31:0] next_push, exp_pop;
    logic        pr, pf, of;
    int          pushed, popped;
    step();
    step();
    check("rst_active_valid", 32'(pop_valid), 0);
    reset = 1'b1;
    step();
    check("idle_valid", 32'(pop_valid), 0);
    check("idle_instr", pop_instr, 32'h0000_0013);
    check("idle_pc", pop_pc, 0);
    check("idle_pc4", pop_pc_plus_4, 32'd4);
    check("idle_count", 32'(count), 0);
    check("idle_ready", 32'(push_ready), 1);
    pop_ready = 1'b1;
    step();
    check("empty_pop_count", 32'(count), 0);
    pop_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_valid = 1'b1;
      push_pc    = 32'(i * 4);
      push_instr = 32'hA0 + 32'(i);
      step();
      check("fill_count", 32'(count), 32'(i + 1));
    end
    check("full_ready", 32'(push_ready), 0);
    push_pc    = 32'h10;
    push_instr = 32'hA4;
    step();
    check("full_push_count", 32'(count), 4);
    check("full_head_pc", pop_pc, 0);
    check("full_head_instr", pop_instr, 32'hA0);
    pop_ready = 1'b1;
    next_push = 32'h10;
    for (int i = 0; i < 5; i++) begin
      push_pc    = next_push;
      push_instr = 32'hA0 + (next_push >> 2);
      check("drain_pc", pop_pc, 32'(i * 4));
      check("drain_instr", pop_instr, 32'hA0 + 32'(i));
      check("drain_pc4", pop_pc_plus_4, 32'(i * 4 + 4));
      pr = push_ready;
      step();
      if (pr) next_push += 32'd4;
      check("drain_count", 32'(count), 3);
    end
    check("pre_flush_head", pop_pc, 32'h14);
    flush      = 1'b1;
    push_pc    = 32'h20;
    push_instr = 32'hA8;
    step();
    flush      = 1'b0;
    push_valid = 1'b0;
    check("flush_count", 32'(count), 0);
    check("flush_valid", 32'(pop_valid), 0);
    check("flush_ready", 32'(push_ready), 1);
    check("flush_instr", pop_instr, 32'h0000_0013);
    step();
    step();
    check("flush_stays_empty", 32'(pop_valid), 0);
    pushed    = 0;
    popped    = 0;
    next_push = 32'h200;
    exp_pop   = 32'h200;
    for (int c = 0; c < 200 && popped < 13; c++) begin
      push_valid = pushed < 13;
      push_pc    = next_push;
      push_instr = next_push ^ 32'hC0DE_0000;
      pop_ready  = (c % 3) != 2;
      pf = push_valid && push_ready;
      of = pop_valid && pop_ready;
      if (of) begin
        check("wrap_pc", pop_pc, exp_pop);
        check("wrap_instr", pop_instr, exp_pop ^ 32'hC0DE_0000);
        exp_pop += 32'd4;
        popped++;
      end
      if (pf) begin
        pushed++;
        next_push += 32'd4;
      end
      step();
      check("wrap_count", 32'(count), 32'(pushed - popped));
      check("wrap_max", 32'(count <= 3'd4), 1);
    end
    check("wrap_popped", 32'(popped), 13);
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    push_valid = 1'b1;
    push_pc    = 32'hFFFF_FFFC;
    push_instr = 32'h1;
    step();
    push_pc    = 32'h304;
    step();
    push_valid = 1'b0;
    check("pc4_wrap", pop_pc_plus_4, 32'h0);
    check("arst_pre_count", 32'(count), 2);
    #3;
    reset = 1'b0;
    #1;
    check("arst_valid", 32'(pop_valid), 0);
    check("arst_count", 32'(count), 0);
    check("arst_ready", 32'(push_ready), 1);
    step();
    reset      = 1'b1;
    push_valid = 1'b1;
    push_pc    = 32'h100;
    push_instr = 32'h55;
    step();
    push_valid = 1'b0;
    check("post_rst_pc", pop_pc, 32'h100);
    check("post_rst_instr", pop_instr, 32'h55);
    check("post_rst_count", 32'(count), 1);
    pop_ready = 1'b1;
    step();
    check("post_rst_drain", 32'(count), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
